fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction decoder in the MIPS core.
- Holds the PC and fetches words from instruction memory over a req/ack handshake that tolerates variable latency.
- Presents one instruction at a time to the decode/execute stage and advances the PC on accept, using that stage's dobranch/dojump results.
- Computes branch and jump targets locally from the held instruction word.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset; must be 4-byte aligned.
- IMEM_TIMEOUT, 16, max cycles waiting for imem_ack before fetch_err is raised; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  word-aligned fetch address; equals pc whenever imem_req=1.
- imem_ack  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  instruction word; valid only when imem_ack=1.
- instr  out  32  held instruction word for the decoder.
- pc  out  32  address of instr.
- pc_plus4  out  32  pc+4, modulo 2^32.
- instr_valid  out  1  instr/pc are valid.
- instr_ready  in  1  consumer retires instr this cycle.
- dobranch  in  1  decoder branch-taken for the held instr; sampled only on accept.
- dojump  in  1  decoder absolute-jump for the held instr; sampled only on accept.
- fetch_err  out  1  sticky timeout flag.

Behaviour:
- Reset (async assert, reset=0):
  - state=IDLE, pc=RESET_PC, instr=32'h0, instr_valid=0.
  - imem_req=0, fetch_err=0, imem_addr=RESET_PC.
  - Wait counter cleared.
- FSM states: IDLE, REQ, HOLD, ERR.
- IDLE:
  - Entered only from reset.
  - Goes to REQ on the first clock edge after reset deasserts.
- REQ:
  - imem_req=1, imem_addr=pc.
  - On imem_ack=1: instr<=imem_rdata, go to HOLD. Zero-wait memory is allowed: ack may arrive in the first REQ cycle.
  - Otherwise the wait counter increments. If IMEM_TIMEOUT!=0 and the counter reaches IMEM_TIMEOUT, go to ERR.
- HOLD:
  - instr_valid=1, imem_req=0. instr and pc are stable until accept.
  - Accept is instr_ready=1. On accept, pc<=next_pc, go to REQ, wait counter cleared.
  - Minimum cadence is one instruction per 2 cycles (REQ with immediate ack, then HOLD with ready).
- next_pc priority (evaluated on accept):
  - dojump=1: {pc_plus4[31:28], instr[25:0], 2'b00}. dojump has priority if both dojump and dobranch are 1.
  - else dobranch=1: pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}.
  - else: pc_plus4.
- Arithmetic is 32-bit modulo. Wrap-around is legal: pc=32'hFFFF_FFFC with no branch gives next pc=32'h0.
- dobranch, dojump and instr_ready are ignored outside HOLD.
- imem_ack is ignored outside REQ; a late or spurious ack never modifies instr.
- ERR:
  - fetch_err=1, imem_req=0, instr_valid=0.
  - Only reset exits ERR.
- Reset asserted mid-fetch abandons the request immediately. The instruction memory must share the same reset so that no stale ack follows.
- All outputs are registered or decoded from state only; there is no combinational path from imem_ack or instr_ready to any output.

Optional Feature:
- Macro: FETCH_PERF_EN.
- With it defined, add two outputs, reset to 0 and saturating at all-ones:
  - perf_fetched (32 bits): counts accepts.
  - perf_stall (32 bits): counts REQ cycles without imem_ack plus HOLD cycles without instr_ready.
- Without it, these ports and counters do not exist and all other behaviour is identical.

Test Plan:
- Reset release with RESET_PC=32'h0040_0000 and zero-wait memory, instr_ready=1 -> imem_addr sequence 0x00400000, 0x00400004, 0x00400008, one REQ per 2 cycles, first imem_req one cycle after reset deasserts.
- Held instr=32'h1000_FFFF at pc=0x00400010, dobranch=1 on accept -> next imem_addr=0x00400010. Same test with instr=32'h1000_0003 -> 0x00400020.
- Held instr=32'h0810_0000 at pc=0x00400000, dojump=1 and dobranch=1 together -> next imem_addr=0x00400000 (jump wins).
- Memory acks after 3 wait cycles, instr_ready held low 4 cycles in HOLD -> instr and pc stable throughout; a spurious ack during HOLD leaves instr unchanged.
- IMEM_TIMEOUT=4, memory never acks -> fetch_err=1 after 4 REQ cycles and stays 1; reset=0 mid-REQ -> imem_req=0 immediately, pc=RESET_PC, fetch_err=0.
- pc=32'hFFFF_FFFC, no branch, accept -> next imem_addr=32'h0. With FETCH_PERF_EN: after the 4-stall scenario, perf_stall=7 and perf_fetched=1.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage upstream of the decoder.
//
// Holds the PC, fetches one word at a time from instruction memory over a
// req/ack handshake of any latency, presents it to decode/execute, and
// advances the PC when the word is accepted. Branch and jump targets are
// computed locally from the held word. The decoder supplies dobranch/dojump
// for that word.
//
// Parameters:
//   RESET_PC      PC loaded on reset (4-byte aligned)
//   IMEM_TIMEOUT  REQ cycles without ack before fetch_err; 0 disables
//
// Ports:
//   clk, reset                  clock, async active-low reset
//   imem_req/imem_addr          fetch request and word address (= pc)
//   imem_ack/imem_rdata         memory response
//   instr/pc/pc_plus4           held instruction, its address, address+4
//   instr_valid/instr_ready     hold handshake with decode/execute
//   dobranch/dojump             control-flow outcome, sampled on accept
//   fetch_err                   sticky memory-timeout flag
//   perf_fetched/perf_stall     (FETCH_PERF_EN only) saturating counters
//
// Optional feature macro: FETCH_PERF_EN
//
// state | meaning
// IDLE  | just out of reset, request starts next cycle
// REQ   | imem_req high, waiting for imem_ack
// HOLD  | instr valid, waiting for instr_ready
// ERR   | memory timed out; only reset leaves
module fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0040_0000,
    parameter int unsigned IMEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        dobranch,
    input  logic        dojump,
    output logic        fetch_err
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] wait_cnt;
    logic [31:0] next_pc;
    logic [31:0] branch_off;
    logic [31:0] jump_tgt;

    assign pc_plus4   = pc + 32'd4;
    assign imem_addr  = pc;
    assign branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign jump_tgt   = {pc_plus4[31:28], instr[25:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (dojump) begin
            next_pc = jump_tgt;
        end else if (dobranch) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            fetch_err   <= 1'b0;
            wait_cnt    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        state       <= HOLD;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        wait_cnt    <= 32'd0;
                    end else if ((IMEM_TIMEOUT != 0) && (wait_cnt == IMEM_TIMEOUT - 1)) begin
                        // this cycle is the IMEM_TIMEOUT-th one without ack
                        state     <= ERR;
                        imem_req  <= 1'b0;
                        fetch_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        pc          <= next_pc;
                        state       <= REQ;
                        imem_req    <= 1'b1;
                        instr_valid <= 1'b0;
                        wait_cnt    <= 32'd0;
                    end
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic stall_evt;
    logic fetch_evt;

    assign stall_evt = ((state == REQ) && !imem_ack) || ((state == HOLD) && !instr_ready);
    assign fetch_evt = (state == HOLD) && instr_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched <= 32'd0;
            perf_stall   <= 32'd0;
        end else begin
            if (fetch_evt && (perf_fetched != 32'hFFFF_FFFF)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (stall_evt && (perf_stall != 32'hFFFF_FFFF)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Instance a uses default parameters;
// instance b starts at the top of the address space with a short timeout.
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // instance a
    logic        rst_a, ack_a, ready_a, br_a, jmp_a;
    logic [31:0] rdata_a;
    logic        req_a, valid_a, err_a;
    logic [31:0] addr_a, instr_a, pc_a, pc4_a;
    // instance b
    logic        rst_b, ack_b, ready_b, br_b, jmp_b;
    logic [31:0] rdata_b;
    logic        req_b, valid_b, err_b;
    logic [31:0] addr_b, instr_b, pc_b, pc4_b;
`ifdef FETCH_PERF_EN
    logic [31:0] pf_fetched_a, pf_stall_a, pf_fetched_b, pf_stall_b;
`endif

    fetch_unit dut_a (
        .clk(clk), .reset(rst_a),
        .imem_req(req_a), .imem_addr(addr_a),
        .imem_ack(ack_a), .imem_rdata(rdata_a),
        .instr(instr_a), .pc(pc_a), .pc_plus4(pc4_a),
        .instr_valid(valid_a), .instr_ready(ready_a),
        .dobranch(br_a), .dojump(jmp_a),
        .fetch_err(err_a)
`ifdef FETCH_PERF_EN
        , .perf_fetched(pf_fetched_a), .perf_stall(pf_stall_a)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .IMEM_TIMEOUT(4)) dut_b (
        .clk(clk), .reset(rst_b),
        .imem_req(req_b), .imem_addr(addr_b),
        .imem_ack(ack_b), .imem_rdata(rdata_b),
        .instr(instr_b), .pc(pc_b), .pc_plus4(pc4_b),
        .instr_valid(valid_b), .instr_ready(ready_b),
        .dobranch(br_b), .dojump(jmp_b),
        .fetch_err(err_b)
`ifdef FETCH_PERF_EN
        , .perf_fetched(pf_fetched_b), .perf_stall(pf_stall_b)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Starts in REQ at a negedge; ends in REQ of the following fetch.
    task automatic fetch_a(input logic [31:0] exp_pc, input logic [31:0] word,
                           input int waits, input int holds,
                           input logic br, input logic jmp);
        check_eq("req_addr", addr_a, exp_pc);
        check_eq("req_high", 32'(req_a), 32'd1);
        for (int i = 0; i < waits; i++) begin
            ack_a = 1'b0;
            tick();
            check_eq("wait_req", 32'(req_a), 32'd1);
            check_eq("wait_valid", 32'(valid_a), 32'd0);
        end
        ack_a   = 1'b1;
        rdata_a = word;
        tick();
        ack_a   = 1'b0;
        rdata_a = 32'hDEAD_BEEF;
        check_eq("hold_valid", 32'(valid_a), 32'd1);
        check_eq("hold_instr", instr_a, word);
        check_eq("hold_pc", pc_a, exp_pc);
        check_eq("hold_pc4", pc4_a, exp_pc + 32'd4);
        check_eq("hold_req", 32'(req_a), 32'd0);
        for (int i = 0; i < holds; i++) begin
            ready_a = 1'b0;
            ack_a   = (i == 1);   // spurious ack while holding
            tick();
            check_eq("stall_instr", instr_a, word);
            check_eq("stall_pc", pc_a, exp_pc);
            check_eq("stall_valid", 32'(valid_a), 32'd1);
        end
        ack_a   = 1'b0;
        ready_a = 1'b1;
        br_a    = br;
        jmp_a   = jmp;
        tick();
        ready_a = 1'b0;
        br_a    = 1'b0;
        jmp_a   = 1'b0;
    endtask

    initial begin
        rst_a = 1'b0; ack_a = 1'b0; ready_a = 1'b0; br_a = 1'b0; jmp_a = 1'b0;
        rdata_a = 32'h0;
        rst_b = 1'b0; ack_b = 1'b0; ready_b = 1'b0; br_b = 1'b0; jmp_b = 1'b0;
        rdata_b = 32'h0;
        tick();
        tick();

        check_eq("rst_pc", pc_a, 32'h0040_0000);
        check_eq("rst_addr", addr_a, 32'h0040_0000);
        check_eq("rst_instr", instr_a, 32'h0);
        check_eq("rst_valid", 32'(valid_a), 32'd0);
        check_eq("rst_req", 32'(req_a), 32'd0);
        check_eq("rst_err", 32'(err_a), 32'd0);

        // zero-wait memory, ready immediately
        rst_a = 1'b1;
        #1 check_eq("idle_req", 32'(req_a), 32'd0);
        @(negedge clk);
        tick();
        fetch_a(32'h0040_0000, 32'h0000_0000, 0, 0, 1'b0, 1'b0);
        fetch_a(32'h0040_0004, 32'h0000_0000, 0, 0, 1'b0, 1'b0);
        fetch_a(32'h0040_0008, 32'h0000_0000, 0, 0, 1'b0, 1'b0);
        fetch_a(32'h0040_000C, 32'h0000_0000, 0, 0, 1'b0, 1'b0);
        // backward branch to itself, then forward branch by 3 words
        fetch_a(32'h0040_0010, 32'h1000_FFFF, 0, 0, 1'b1, 1'b0);
        fetch_a(32'h0040_0010, 32'h1000_0003, 0, 0, 1'b1, 1'b0);
        check_eq("br_fwd_addr", addr_a, 32'h0040_0020);
        check_eq("br_fwd_req", 32'(req_a), 32'd1);

        // reset while a request is outstanding
        #2 rst_a = 1'b0;
        #1;
        check_eq("midreq_req", 32'(req_a), 32'd0);
        check_eq("midreq_pc", pc_a, 32'h0040_0000);
        @(negedge clk);
        tick();
        rst_a = 1'b1;
        tick();

        // slow memory, stalled consumer, jump and branch together
        fetch_a(32'h0040_0000, 32'h0810_0000, 3, 4, 1'b1, 1'b1);
        check_eq("jmp_addr", addr_a, 32'h0040_0000);
`ifdef FETCH_PERF_EN
        check_eq("perf_stall", pf_stall_a, 32'd7);
        check_eq("perf_fetched", pf_fetched_a, 32'd1);
`endif

        // instance b: wrap-around, then timeout
        rst_b = 1'b1;
        tick();
        check_eq("b_req", 32'(req_b), 32'd1);
        check_eq("b_addr", addr_b, 32'hFFFF_FFFC);
        ack_b   = 1'b1;
        rdata_b = 32'h0000_1234;
        tick();
        ack_b   = 1'b0;
        check_eq("b_valid", 32'(valid_b), 32'd1);
        check_eq("b_pc4_wrap", pc4_b, 32'h0);
        ready_b = 1'b1;
        tick();
        ready_b = 1'b0;
        check_eq("b_wrap_addr", addr_b, 32'h0);
        check_eq("b_wrap_req", 32'(req_b), 32'd1);
        tick();
        tick();
        tick();
        check_eq("b_pre_to_err", 32'(err_b), 32'd0);
        check_eq("b_pre_to_req", 32'(req_b), 32'd1);
        tick();
        check_eq("b_to_err", 32'(err_b), 32'd1);
        check_eq("b_to_req", 32'(req_b), 32'd0);
        check_eq("b_to_valid", 32'(valid_b), 32'd0);
        ack_b   = 1'b1;
        rdata_b = 32'hCAFE_F00D;
        ready_b = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        ack_b   = 1'b0;
        ready_b = 1'b0;
        check_eq("b_err_sticky", 32'(err_b), 32'd1);
        check_eq("b_err_req", 32'(req_b), 32'd0);
        check_eq("b_err_instr", instr_b, 32'h0000_1234);

        rst_b = 1'b0;
        #1 check_eq("b_rst_err", 32'(err_b), 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        tick();
        check_eq("b_req2", 32'(req_b), 32'd1);
        #2 rst_b = 1'b0;
        #1;
        check_eq("b_midreq_req", 32'(req_b), 32'd0);
        check_eq("b_midreq_pc", pc_b, 32'hFFFF_FFFC);
        check_eq("b_midreq_err", 32'(err_b), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
